// File: rtl/mrh_pkg.sv
// Shared front-end types and I-cache geometry for the fetch path.
// Pure declarations: no logic, no latency, no flow control.
package mrh_pkg;

    localparam int ICACHE_DATA_W   = 128;
    localparam int ICACHE_DATA_B_W = ICACHE_DATA_W / 8;
    localparam int ICACHE_OFS_W    = $clog2(ICACHE_DATA_B_W);

    typedef enum logic [1:0] {
        FETCH_REQ,
        FETCH_WAIT,
        FETCH_KILL
    } fetch_state_t;

endpackage

// File: rtl/ic_fetch_ctrl_byte_en_gen.sv
// Offset -> thermometer byte-enable mask (bytes at or above the offset are valid).
// Purely combinational, zero latency, no flow control.
module fetch_byte_en_gen
    import mrh_pkg::*;
(
    input  logic [ICACHE_OFS_W-1:0]    i_ofs,
    output logic [ICACHE_DATA_B_W-1:0] o_byte_en
);

    for (genvar g = 0; g < ICACHE_DATA_B_W; g++) begin : g_be
        assign o_byte_en[g] = (ICACHE_OFS_W'(g) >= i_ofs);
    end

endmodule

// File: rtl/ic_fetch_ctrl.sv
// Fetch controller: one outstanding I-cache request, one-slot output stage, redirect flush.
// Response to o_inst_vld is 1 cycle; requests stall while the slot cannot drain (i_inst_rdy).
// FETCH_PERF_CNT_EN adds saturating stall / discarded-response counters.
module ic_fetch_ctrl
    import mrh_pkg::*;
#(
    parameter int                 VADDR_W  = 39,
    parameter logic [VADDR_W-1:0] RESET_PC = 'h8000_0000
) (
    input  logic                       i_clk,
    input  logic                       i_reset,
    input  logic                       i_redirect_vld,
    input  logic [VADDR_W-1:0]         i_redirect_pc,
    output logic                       o_ic_req_vld,
    output logic [VADDR_W-1:0]         o_ic_req_vaddr,
    input  logic                       i_ic_req_rdy,
    input  logic                       i_ic_resp_vld,
    input  logic [ICACHE_DATA_W-1:0]   i_ic_resp_data,
    output logic                       o_inst_vld,
    output logic [ICACHE_DATA_W-1:0]   o_inst_data,
    output logic [ICACHE_DATA_B_W-1:0] o_inst_byte_en,
    output logic [VADDR_W-1:0]         o_inst_pc,
`ifdef FETCH_PERF_CNT_EN
    output logic [31:0]                o_perf_req_stall,
    output logic [31:0]                o_perf_kill_cnt,
`endif
    input  logic                       i_inst_rdy
);

    fetch_state_t r_state;
    fetch_state_t w_state_nxt;

    logic [VADDR_W-1:0]         r_pc;
    logic                       r_inst_vld;
    logic [ICACHE_DATA_W-1:0]   r_inst_data;
    logic [ICACHE_DATA_B_W-1:0] r_inst_be;
    logic [VADDR_W-1:0]         r_inst_pc;

    logic                       w_slot_free;
    logic                       w_req_fire;
    logic                       w_resp_take;
    logic [VADDR_W-1:0]         w_pc_aligned;
    logic [VADDR_W-1:0]         w_pc_seq;
    logic [ICACHE_DATA_B_W-1:0] w_byte_en;

    assign w_pc_aligned = {r_pc[VADDR_W-1:ICACHE_OFS_W], {ICACHE_OFS_W{1'b0}}};
    assign w_pc_seq     = w_pc_aligned + VADDR_W'(ICACHE_DATA_B_W);

    // Only issue when the slot will be free by the time any response could land.
    assign w_slot_free    = !r_inst_vld || i_inst_rdy;
    assign o_ic_req_vld   = !i_reset && (r_state == FETCH_REQ) && w_slot_free;
    assign o_ic_req_vaddr = w_pc_aligned;
    assign w_req_fire     = o_ic_req_vld && i_ic_req_rdy;
    assign w_resp_take    = (r_state == FETCH_WAIT) && i_ic_resp_vld && !i_redirect_vld;

    fetch_byte_en_gen u_be_gen (
        .i_ofs     (r_pc[ICACHE_OFS_W-1:0]),
        .o_byte_en (w_byte_en)
    );

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state <= FETCH_REQ;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            FETCH_REQ: begin
                if (w_req_fire) begin
                    w_state_nxt = i_redirect_vld ? FETCH_KILL : FETCH_WAIT;
                end
            end
            FETCH_WAIT: begin
                if (i_ic_resp_vld) begin
                    w_state_nxt = FETCH_REQ;
                end else if (i_redirect_vld) begin
                    w_state_nxt = FETCH_KILL;
                end
            end
            FETCH_KILL: begin
                if (i_ic_resp_vld) begin
                    w_state_nxt = FETCH_REQ;
                end
            end
            default: w_state_nxt = FETCH_REQ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_pc        <= RESET_PC;
            r_inst_vld  <= 1'b0;
            r_inst_data <= '0;
            r_inst_be   <= '0;
            r_inst_pc   <= '0;
        end else begin
            if (i_redirect_vld) begin
                r_pc <= i_redirect_pc;
            end else if (w_resp_take) begin
                r_pc <= w_pc_seq;
            end

            if (i_redirect_vld) begin
                r_inst_vld <= 1'b0;
            end else if (w_resp_take) begin
                r_inst_vld  <= 1'b1;
                r_inst_data <= i_ic_resp_data;
                r_inst_be   <= w_byte_en;
                r_inst_pc   <= r_pc;
            end else if (r_inst_vld && i_inst_rdy) begin
                r_inst_vld <= 1'b0;
            end
        end
    end

    assign o_inst_vld     = r_inst_vld;
    assign o_inst_data    = r_inst_data;
    assign o_inst_byte_en = r_inst_be;
    assign o_inst_pc      = r_inst_pc;

`ifdef FETCH_PERF_CNT_EN
    logic        w_resp_drop;
    logic        w_req_stall;
    logic [31:0] r_perf_req_stall;
    logic [31:0] r_perf_kill_cnt;

    assign w_req_stall = o_ic_req_vld && !i_ic_req_rdy;
    assign w_resp_drop = i_ic_resp_vld &&
                         ((r_state == FETCH_KILL) || ((r_state == FETCH_WAIT) && i_redirect_vld));

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_perf_req_stall <= '0;
            r_perf_kill_cnt  <= '0;
        end else begin
            if (w_req_stall && (r_perf_req_stall != '1)) begin
                r_perf_req_stall <= r_perf_req_stall + 32'd1;
            end
            if (w_resp_drop && (r_perf_kill_cnt != '1)) begin
                r_perf_kill_cnt <= r_perf_kill_cnt + 32'd1;
            end
        end
    end

    assign o_perf_req_stall = r_perf_req_stall;
    assign o_perf_kill_cnt  = r_perf_kill_cnt;
`endif

    a_no_resp_in_req: assert property (@(posedge i_clk) disable iff (i_reset)
        !((r_state == FETCH_REQ) && i_ic_resp_vld));

endmodule

// File: tb/tb_ic_fetch_ctrl.sv
// Directed self-checking bench for ic_fetch_ctrl (ICACHE_DATA_B_W = 16).
module tb_ic_fetch_ctrl;
    import mrh_pkg::*;

    localparam int VW = 39;

    logic                       clk = 1'b0;
    logic                       rst;
    logic                       redirect_vld;
    logic [VW-1:0]              redirect_pc;
    logic                       req_vld;
    logic [VW-1:0]              req_vaddr;
    logic                       req_rdy;
    logic                       resp_vld;
    logic [ICACHE_DATA_W-1:0]   resp_data;
    logic                       inst_vld;
    logic [ICACHE_DATA_W-1:0]   inst_data;
    logic [ICACHE_DATA_B_W-1:0] inst_be;
    logic [VW-1:0]              inst_pc;
    logic                       inst_rdy;
`ifdef FETCH_PERF_CNT_EN
    logic [31:0]                perf_stall;
    logic [31:0]                perf_kill;
`endif

    int checks = 0;
    int errors = 0;
    logic [ICACHE_DATA_W-1:0] exp_d;

    always #5 clk = ~clk;

    ic_fetch_ctrl #(.VADDR_W(VW), .RESET_PC(39'h8000_0000)) dut (
        .i_clk          (clk),
        .i_reset        (rst),
        .i_redirect_vld (redirect_vld),
        .i_redirect_pc  (redirect_pc),
        .o_ic_req_vld   (req_vld),
        .o_ic_req_vaddr (req_vaddr),
        .i_ic_req_rdy   (req_rdy),
        .i_ic_resp_vld  (resp_vld),
        .i_ic_resp_data (resp_data),
        .o_inst_vld     (inst_vld),
        .o_inst_data    (inst_data),
        .o_inst_byte_en (inst_be),
        .o_inst_pc      (inst_pc),
`ifdef FETCH_PERF_CNT_EN
        .o_perf_req_stall (perf_stall),
        .o_perf_kill_cnt  (perf_kill),
`endif
        .i_inst_rdy     (inst_rdy)
    );

    initial begin
        #50000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Drives a response one idle cycle after the accept edge.
    task automatic resp_after_accept(input logic [ICACHE_DATA_W-1:0] d);
        tick();
        tick();
        resp_vld = 1'b1; resp_data = d;
        tick();
        resp_vld = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        rst = 1'b1; redirect_vld = 1'b0; redirect_pc = '0; req_rdy = 1'b1;
        resp_vld = 1'b0; resp_data = '0; inst_rdy = 1'b1;
        tick(); tick(); #1;
        checks++; if (req_vld !== 1'b0) begin errors++; $display("FAIL reset_req_vld got %b exp 0", req_vld); end
        checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL reset_inst_vld got %b exp 0", inst_vld); end
        checks++; if (inst_be !== 16'h0 || inst_pc !== '0 || inst_data !== '0) begin
            errors++; $display("FAIL reset_outputs be %h pc %h data %h exp 0", inst_be, inst_pc, inst_data); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall !== 32'd0 || perf_kill !== 32'd0) begin
            errors++; $display("FAIL reset_perf stall %0d kill %0d exp 0", perf_stall, perf_kill); end
`endif
        rst = 1'b0;
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            #1;
            checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0000 + 39'(16 * i)) begin
                errors++; $display("FAIL seq_req[%0d] vld %b addr %h exp 1 %h", i, req_vld, req_vaddr, 39'h8000_0000 + 39'(16 * i)); end
            tick(); #1;
            checks++; if (req_vld !== 1'b0 || inst_vld !== 1'b0) begin
                errors++; $display("FAIL seq_wait[%0d] req_vld %b inst_vld %b exp 0 0", i, req_vld, inst_vld); end
            tick();
            exp_d = {4{32'hC0DE_0000 | 32'(i)}};
            resp_vld = 1'b1; resp_data = exp_d;
            tick();
            resp_vld = 1'b0; #1;
            checks++; if (inst_vld !== 1'b1 || inst_data !== exp_d || inst_be !== 16'hFFFF || inst_pc !== 39'h8000_0000 + 39'(16 * i)) begin
                errors++; $display("FAIL seq_out[%0d] vld %b be %h pc %h data %h exp 1 ffff %h %h", i, inst_vld, inst_be, inst_pc,
                                   inst_data, 39'h8000_0000 + 39'(16 * i), exp_d); end
        end
    endtask

    task automatic test_redirect_unaligned();
        inst_rdy = 1'b0; req_rdy = 1'b0;
        redirect_vld = 1'b1; redirect_pc = 39'h8000_0006;
        tick();
        redirect_vld = 1'b0; inst_rdy = 1'b1; req_rdy = 1'b1; #1;
        checks++; if (inst_vld !== 1'b0 || req_vld !== 1'b1 || req_vaddr !== 39'h8000_0000) begin
            errors++; $display("FAIL redir_req inst_vld %b req_vld %b addr %h exp 0 1 80000000", inst_vld, req_vld, req_vaddr); end
        resp_after_accept({4{32'hAAAA_0006}});
        checks++; if (inst_vld !== 1'b1 || inst_be !== 16'hFFC0 || inst_pc !== 39'h8000_0006 || inst_data !== {4{32'hAAAA_0006}}) begin
            errors++; $display("FAIL redir_out vld %b be %h pc %h exp 1 ffc0 80000006", inst_vld, inst_be, inst_pc); end
        checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0010) begin
            errors++; $display("FAIL redir_next_req vld %b addr %h exp 1 80000010", req_vld, req_vaddr); end
        resp_after_accept({4{32'hAAAA_0010}});
        checks++; if (inst_vld !== 1'b1 || inst_be !== 16'hFFFF || inst_pc !== 39'h8000_0010) begin
            errors++; $display("FAIL redir_seq_out vld %b be %h pc %h exp 1 ffff 80000010", inst_vld, inst_be, inst_pc); end
    endtask

    task automatic test_redirect_wait();
        tick();
        redirect_vld = 1'b1; redirect_pc = 39'h8000_0104;
        tick();
        redirect_vld = 1'b0;
        for (int k = 0; k < 2; k++) begin
            #1;
            checks++; if (req_vld !== 1'b0 || inst_vld !== 1'b0) begin
                errors++; $display("FAIL kill_idle[%0d] req_vld %b inst_vld %b exp 0 0", k, req_vld, inst_vld); end
            tick();
        end
        resp_vld = 1'b1; resp_data = {4{32'hDEAD_BEEF}};
        tick();
        resp_vld = 1'b0; #1;
        checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL kill_drop inst_vld %b exp 0", inst_vld); end
        checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0100) begin
            errors++; $display("FAIL kill_next_req vld %b addr %h exp 1 80000100", req_vld, req_vaddr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_kill !== 32'd1) begin errors++; $display("FAIL perf_kill_1 got %0d exp 1", perf_kill); end
`endif
        resp_after_accept({4{32'h1234_0104}});
        checks++; if (inst_vld !== 1'b1 || inst_be !== 16'hFFF0 || inst_pc !== 39'h8000_0104 || inst_data !== {4{32'h1234_0104}}) begin
            errors++; $display("FAIL kill_refetch vld %b be %h pc %h exp 1 fff0 80000104", inst_vld, inst_be, inst_pc); end
    endtask

    task automatic test_backpressure();
        inst_rdy = 1'b0;
        for (int k = 0; k < 5; k++) begin
            #1;
            checks++; if (req_vld !== 1'b0 || inst_vld !== 1'b1 || inst_pc !== 39'h8000_0104 || inst_data !== {4{32'h1234_0104}}) begin
                errors++; $display("FAIL bp_hold[%0d] req_vld %b inst_vld %b pc %h exp 0 1 80000104", k, req_vld, inst_vld, inst_pc); end
            tick();
        end
        inst_rdy = 1'b1; #1;
        checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0110) begin
            errors++; $display("FAIL bp_release vld %b addr %h exp 1 80000110", req_vld, req_vaddr); end
        tick(); #1;
        checks++; if (inst_vld !== 1'b0) begin errors++; $display("FAIL bp_drain inst_vld %b exp 0", inst_vld); end
        tick();
        resp_vld = 1'b1; resp_data = {4{32'h5555_0110}};
        tick();
        resp_vld = 1'b0; #1;
        checks++; if (inst_vld !== 1'b1 || inst_be !== 16'hFFFF || inst_pc !== 39'h8000_0110) begin
            errors++; $display("FAIL bp_out vld %b be %h pc %h exp 1 ffff 80000110", inst_vld, inst_be, inst_pc); end
    endtask

    task automatic test_redirect_with_resp();
        tick();
        tick();
        resp_vld = 1'b1; resp_data = {4{32'hBAD0_BAD0}};
        redirect_vld = 1'b1; redirect_pc = 39'h8000_0200;
        tick();
        resp_vld = 1'b0; redirect_vld = 1'b0; #1;
        checks++; if (inst_vld !== 1'b0 || req_vld !== 1'b1 || req_vaddr !== 39'h8000_0200) begin
            errors++; $display("FAIL rr_state inst_vld %b req_vld %b addr %h exp 0 1 80000200", inst_vld, req_vld, req_vaddr); end
        resp_after_accept({4{32'h7777_0200}});
        checks++; if (inst_vld !== 1'b1 || inst_pc !== 39'h8000_0200 || inst_be !== 16'hFFFF || inst_data !== {4{32'h7777_0200}}) begin
            errors++; $display("FAIL rr_out vld %b be %h pc %h exp 1 ffff 80000200", inst_vld, inst_be, inst_pc); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_kill !== 32'd2) begin errors++; $display("FAIL perf_kill_2 got %0d exp 2", perf_kill); end
`endif
    endtask

    task automatic test_stall();
        req_rdy = 1'b0;
        for (int k = 0; k < 4; k++) begin
            #1;
            checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0210) begin
                errors++; $display("FAIL stall_req[%0d] vld %b addr %h exp 1 80000210", k, req_vld, req_vaddr); end
            tick();
        end
        #1;
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall !== 32'd4) begin errors++; $display("FAIL perf_stall got %0d exp 4", perf_stall); end
`endif
        req_rdy = 1'b1;
    endtask

    task automatic test_reset_midop();
        resp_after_accept({4{32'h9999_0210}});
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0; #1;
        checks++; if (inst_vld !== 1'b0 || inst_pc !== '0 || inst_be !== 16'h0) begin
            errors++; $display("FAIL midrst_slot vld %b pc %h be %h exp 0 0 0", inst_vld, inst_pc, inst_be); end
        checks++; if (req_vld !== 1'b1 || req_vaddr !== 39'h8000_0000) begin
            errors++; $display("FAIL midrst_req vld %b addr %h exp 1 80000000", req_vld, req_vaddr); end
`ifdef FETCH_PERF_CNT_EN
        checks++; if (perf_stall !== 32'd0 || perf_kill !== 32'd0) begin
            errors++; $display("FAIL midrst_perf stall %0d kill %0d exp 0", perf_stall, perf_kill); end
`endif
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_redirect_unaligned();
        test_redirect_wait();
        test_backpressure();
        test_redirect_with_resp();
        test_stall();
        test_reset_midop();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
